// File: rtl/rom_boot_copier.sv
// Boot copier: streams every boot ROM byte into data RAM, then releases the CPU from reset.
// Latency: first RAM write 3 cycles after reset/restart; done and cpu_reset rise N+3 cycles after.
// No backpressure: one ROM byte per cycle, N gap-free writes. Optional magic check: BOOT_MAGIC_CHECK_EN.
module rom_boot_copier #(
  parameter int ROM_ADDR_W = 7,
  parameter int RAM_ADDR_W = 8,
  parameter int RAM_BASE   = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  restart,
  output logic [ROM_ADDR_W-1:0] rom_addr,
  output logic                  rom_enable_out,
  input  logic [7:0]            rom_data,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic [7:0]            ram_data,
  output logic                  ram_write_en,
  output logic                  cpu_reset,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [1:0] {S_IDLE, S_COPY, S_DONE, S_ERROR} state_t;

  localparam logic [ROM_ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [RAM_ADDR_W-1:0] BASE_ADDR = RAM_ADDR_W'(RAM_BASE);

  state_t                  r_state;
  state_t                  w_next;
  logic [ROM_ADDR_W-1:0]   r_rom_addr;
  logic                    r_issue_end;  // last ROM address has been presented
  logic                    r_rsp_vld;    // rom_data this cycle belongs to r_rsp_addr
  logic [ROM_ADDR_W-1:0]   r_rsp_addr;
  logic [RAM_ADDR_W-1:0]   r_ram_addr;
  logic [7:0]              r_ram_data;
  logic                    r_ram_we;
  logic                    r_wr_last;    // the write currently on the port is the final byte
  logic                    w_mismatch;

`ifdef BOOT_MAGIC_CHECK_EN
  // Program magic "ASRM", one byte per ROM address 0..3.
  function automatic logic [7:0] magic_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    magic_byte = 8'h41;
      2'd1:    magic_byte = 8'h53;
      2'd2:    magic_byte = 8'h52;
      default: magic_byte = 8'h4D;
    endcase
  endfunction

  assign w_mismatch = (r_state == S_COPY) && r_rsp_vld &&
                      ((r_rsp_addr >> 2) == '0) &&
                      (rom_data != magic_byte(r_rsp_addr[1:0]));
  assign error      = (r_state == S_ERROR);
`else
  assign w_mismatch = 1'b0;
  assign error      = 1'b0;
`endif

  // State register; reset always lands in IDLE.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state: copy starts right after reset, finishes once the last byte's write is on the port.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = S_COPY;
      S_COPY: begin
        if (w_mismatch)                  w_next = S_ERROR;
        else if (r_ram_we && r_wr_last)  w_next = S_DONE;
      end
      S_DONE:  if (restart) w_next = S_COPY;
      S_ERROR: if (restart) w_next = S_COPY;
      default: w_next = S_IDLE;
    endcase
  end

  // ROM address issue, ROM response tracking and RAM write port registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_rom_addr  <= '0;
      r_issue_end <= 1'b0;
      r_rsp_vld   <= 1'b0;
      r_rsp_addr  <= '0;
      r_ram_addr  <= BASE_ADDR;
      r_ram_data  <= 8'h00;
      r_ram_we    <= 1'b0;
      r_wr_last   <= 1'b0;
    end else if ((r_state != S_COPY) && (w_next == S_COPY)) begin
      // Entering a fresh copy: address 0 goes out on this edge.
      r_rom_addr  <= '0;
      r_issue_end <= 1'b0;
      r_rsp_vld   <= 1'b0;
      r_ram_addr  <= BASE_ADDR;
      r_ram_we    <= 1'b0;
      r_wr_last   <= 1'b0;
    end else if (w_next == S_COPY) begin
      r_rsp_vld  <= !r_issue_end;
      r_rsp_addr <= r_rom_addr;
      if (!r_issue_end) begin
        if (r_rom_addr == LAST_ADDR) r_issue_end <= 1'b1;
        else                         r_rom_addr  <= r_rom_addr + 1'b1;
      end
      r_ram_we  <= r_rsp_vld;
      r_wr_last <= r_rsp_vld && (r_rsp_addr == LAST_ADDR);
      if (r_rsp_vld) begin
        r_ram_addr <= BASE_ADDR + RAM_ADDR_W'(r_rsp_addr);
        r_ram_data <= rom_data;
      end
    end else begin
      // Leaving COPY (to DONE or ERROR) or parked: no strobes, a mismatching byte is dropped.
      r_rsp_vld <= 1'b0;
      r_ram_we  <= 1'b0;
      r_wr_last <= 1'b0;
    end
  end

  assign rom_addr       = r_rom_addr;
  assign rom_enable_out = (r_state == S_COPY);
  assign ram_addr       = r_ram_addr;
  assign ram_data       = r_ram_data;
  assign ram_write_en   = r_ram_we;
  assign done           = (r_state == S_DONE);
  assign cpu_reset      = (r_state == S_DONE);

endmodule

// File: tb/tb_rom_boot_copier.sv
// Directed bench for rom_boot_copier: default base and a wrapping base (0xF0) side by side.
// Cycle numbers are counted from the reset/restart release (first edge with it released = 1).
// Works with BOOT_MAGIC_CHECK_EN defined or not.
module tb_rom_boot_copier;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic restart = 1'b0;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  logic [7:0] rom [128];

  logic [6:0] rom_addr0, rom_addr1;
  logic       rom_en0, rom_en1;
  logic [7:0] rom_q0 = 8'h00, rom_q1 = 8'h00;
  logic [7:0] ram_addr0, ram_addr1, ram_data0, ram_data1;
  logic       ram_we0, ram_we1, cpu_rst0, cpu_rst1, done0, done1, err0, err1;

  logic [7:0] log_addr0[$], log_data0[$], log_addr1[$], log_data1[$];
  int         log_cyc0[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rom_boot_copier dut0 (
    .clk(clk), .reset(reset), .restart(restart),
    .rom_addr(rom_addr0), .rom_enable_out(rom_en0), .rom_data(rom_q0),
    .ram_addr(ram_addr0), .ram_data(ram_data0), .ram_write_en(ram_we0),
    .cpu_reset(cpu_rst0), .done(done0), .error(err0)
  );

  rom_boot_copier #(.ROM_ADDR_W(7), .RAM_ADDR_W(8), .RAM_BASE(8'hF0)) dut1 (
    .clk(clk), .reset(reset), .restart(restart),
    .rom_addr(rom_addr1), .rom_enable_out(rom_en1), .rom_data(rom_q1),
    .ram_addr(ram_addr1), .ram_data(ram_data1), .ram_write_en(ram_we1),
    .cpu_reset(cpu_rst1), .done(done1), .error(err1)
  );

  // Synchronous ROM models: data one cycle after address, zero when disabled.
  always @(posedge clk) begin
    rom_q0 <= rom_en0 ? rom[rom_addr0] : 8'h00;
    rom_q1 <= rom_en1 ? rom[rom_addr1] : 8'h00;
  end

  // RAM write monitors, sampled mid-cycle.
  always @(negedge clk) begin
    if (ram_we0) begin
      log_addr0.push_back(ram_addr0);
      log_data0.push_back(ram_data0);
      log_cyc0.push_back(cyc);
    end
    if (ram_we1) begin
      log_addr1.push_back(ram_addr1);
      log_data1.push_back(ram_data1);
    end
  end

  function automatic logic [7:0] image_byte(input int i);
    if (i == 0)         return 8'h41;
    else if (i == 1)    return 8'h53;
    else if (i == 2)    return 8'h52;
    else if (i == 3)    return 8'h4D;
    else if (i < 8'h5F) return 8'((i * 3) + 1);
    else if (i == 8'h5F) return 8'h08;
    else                return 8'h00;
  endfunction

  task automatic clear_logs();
    log_addr0.delete(); log_data0.delete(); log_cyc0.delete();
    log_addr1.delete(); log_data1.delete();
  endtask

  task automatic reset_and_release(output int t0);
    @(negedge clk);
    reset = 1'b0;
    restart = 1'b0;
    repeat (2) @(negedge clk);
    clear_logs();
    reset = 1'b1;
    t0 = cyc;
  endtask

  // Bounded wait for done; also notes any cycle where cpu_reset and done disagree.
  task automatic wait_done(output int dcyc, output bit split);
    dcyc = -1;
    split = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (cpu_rst0 !== done0) split = 1'b1;
      if (done0 === 1'b1) begin
        dcyc = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (rom_addr0 !== 7'd0) begin errors++; $display("FAIL reset_rom_addr got=%0h want=0", rom_addr0); end
    checks++; if (rom_en0 !== 1'b0) begin errors++; $display("FAIL reset_rom_en got=%b want=0", rom_en0); end
    checks++; if (ram_addr0 !== 8'h00) begin errors++; $display("FAIL reset_ram_addr got=%0h want=0", ram_addr0); end
    checks++; if (ram_addr1 !== 8'hF0) begin errors++; $display("FAIL reset_ram_addr_base got=%0h want=f0", ram_addr1); end
    checks++; if (ram_data0 !== 8'h00) begin errors++; $display("FAIL reset_ram_data got=%0h want=0", ram_data0); end
    checks++; if ({ram_we0, cpu_rst0, done0, err0} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got we/cpu/done/err=%b want=0000", {ram_we0, cpu_rst0, done0, err0});
    end
  endtask

  task automatic test_copy_default();
    int t0, dcyc, bad_wr, bad_zero, bad_wrap;
    bit split;
    logic [7:0] ram [256];
    reset_and_release(t0);
    wait_done(dcyc, split);
    checks++; if (dcyc !== t0 + 131) begin errors++; $display("FAIL copy_done_cycle got=%0d want=%0d", dcyc - t0, 131); end
    checks++; if (split !== 1'b0 || cpu_rst0 !== 1'b1) begin errors++; $display("FAIL copy_cpu_reset split=%b cpu_reset=%b want 0/1", split, cpu_rst0); end
    checks++; if (err0 !== 1'b0) begin errors++; $display("FAIL copy_error got=%b want=0", err0); end
    checks++; if (log_addr0.size() != 128) begin errors++; $display("FAIL copy_write_count got=%0d want=128", log_addr0.size()); end
    if (log_addr0.size() == 128) begin
      checks++; if (log_cyc0[0] != t0 + 3) begin errors++; $display("FAIL copy_first_strobe got=%0d want=3", log_cyc0[0] - t0); end
      checks++; if (log_cyc0[127] != t0 + 130) begin errors++; $display("FAIL copy_no_gaps last_strobe got=%0d want=130", log_cyc0[127] - t0); end
      for (int i = 0; i < 256; i++) ram[i] = 8'h00;
      bad_wr = 0;
      for (int i = 0; i < 128; i++) begin
        ram[log_addr0[i]] = log_data0[i];
        if (log_addr0[i] !== 8'(i) || log_data0[i] !== image_byte(i)) bad_wr++;
      end
      checks++; if ({ram[0], ram[1], ram[2], ram[3]} !== 32'h4153524D) begin
        errors++; $display("FAIL copy_magic got=%h want=4153524d", {ram[0], ram[1], ram[2], ram[3]});
      end
      checks++; if (ram[8'h5F] !== 8'h08) begin errors++; $display("FAIL copy_byte5f got=%0h want=08", ram[8'h5F]); end
      bad_zero = 0;
      for (int i = 8'h60; i < 8'h80; i++) if (ram[i] !== 8'h00) bad_zero++;
      checks++; if (bad_zero != 0) begin errors++; $display("FAIL copy_tail_zero nonzero=%0d want=0", bad_zero); end
      checks++; if (bad_wr != 0) begin errors++; $display("FAIL copy_sequence bad_entries=%0d want=0", bad_wr); end
    end
    // Wrapping base instance ran alongside.
    checks++; if (log_addr1.size() != 128 || done1 !== 1'b1) begin
      errors++; $display("FAIL wrap_count got=%0d done=%b want=128/1", log_addr1.size(), done1);
    end
    if (log_addr1.size() == 128) begin
      checks++; if (log_addr1[16] !== 8'h00 || log_data1[16] !== image_byte(16)) begin
        errors++; $display("FAIL wrap_byte10 addr=%0h data=%0h want=00/%0h", log_addr1[16], log_data1[16], image_byte(16));
      end
      bad_wrap = 0;
      for (int i = 0; i < 128; i++) if (log_addr1[i] !== 8'(8'hF0 + i)) bad_wrap++;
      checks++; if (bad_wrap != 0) begin errors++; $display("FAIL wrap_addresses bad=%0d want=0", bad_wrap); end
    end
  endtask

  task automatic test_restart_in_copy();
    int t0, dcyc;
    bit split;
    reset_and_release(t0);
    repeat (50) @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    wait_done(dcyc, split);
    checks++; if (dcyc !== t0 + 131 || log_addr0.size() != 128) begin
      errors++; $display("FAIL restart_in_copy done_cycle=%0d writes=%0d want=131/128", dcyc - t0, log_addr0.size());
    end
  endtask

  task automatic test_restart_done();
    int r0, dcyc;
    bit split;
    @(negedge clk);
    clear_logs();
    restart = 1'b1;
    r0 = cyc;
    @(negedge clk);
    restart = 1'b0;
    checks++; if (done0 !== 1'b0 || cpu_rst0 !== 1'b0) begin
      errors++; $display("FAIL restart_clears done=%b cpu_reset=%b want=0/0", done0, cpu_rst0);
    end
    wait_done(dcyc, split);
    checks++; if (dcyc !== r0 + 131 || log_addr0.size() != 128) begin
      errors++; $display("FAIL restart_recopy done_cycle=%0d writes=%0d want=131/128", dcyc - r0, log_addr0.size());
    end
    checks++; if (log_cyc0.size() == 0 || log_cyc0[0] != r0 + 3) begin
      errors++; $display("FAIL restart_first_strobe got=%0d want=3", (log_cyc0.size() == 0) ? -1 : log_cyc0[0] - r0);
    end
  endtask

  task automatic test_reset_midcopy();
    int t0, t1, dcyc;
    bit split;
    reset_and_release(t0);
    repeat (53) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checks++; if ({ram_we0, rom_en0, cpu_rst0, done0, err0} !== 5'b00000) begin
      errors++; $display("FAIL midreset_flags we/en/cpu/done/err=%b want=00000", {ram_we0, rom_en0, cpu_rst0, done0, err0});
    end
    checks++; if (rom_addr0 !== 7'd0 || ram_addr0 !== 8'h00 || ram_data0 !== 8'h00) begin
      errors++; $display("FAIL midreset_values rom_addr=%0h ram_addr=%0h ram_data=%0h want=0/0/0", rom_addr0, ram_addr0, ram_data0);
    end
    checks++; if (log_addr0.size() != 51) begin errors++; $display("FAIL midreset_writes got=%0d want=51", log_addr0.size()); end
    clear_logs();
    reset = 1'b1;
    t1 = cyc;
    wait_done(dcyc, split);
    checks++; if (dcyc !== t1 + 131 || log_addr0.size() != 128) begin
      errors++; $display("FAIL midreset_recopy done_cycle=%0d writes=%0d want=131/128", dcyc - t1, log_addr0.size());
    end
    checks++; if (log_addr0.size() == 0 || log_addr0[0] !== 8'h00 || log_cyc0[0] != t1 + 3) begin
      errors++; $display("FAIL midreset_restart_addr0 size=%0d", log_addr0.size());
    end
  endtask

  task automatic test_magic();
    int t0, ecyc, dcyc;
    rom[2] = 8'h00;
    reset_and_release(t0);
    ecyc = -1;
    dcyc = -1;
    for (int k = 0; k < 140; k++) begin
      @(negedge clk);
      if (err0 === 1'b1 && ecyc < 0) ecyc = cyc;
      if (done0 === 1'b1 && dcyc < 0) dcyc = cyc;
    end
`ifdef BOOT_MAGIC_CHECK_EN
    checks++; if (ecyc !== t0 + 5) begin errors++; $display("FAIL magic_error_cycle got=%0d want=5", ecyc - t0); end
    checks++; if (log_addr0.size() != 2) begin errors++; $display("FAIL magic_write_count got=%0d want=2", log_addr0.size()); end
    checks++; if (log_addr0.size() == 2 && (log_addr0[0] !== 8'h00 || log_addr0[1] !== 8'h01)) begin
      errors++; $display("FAIL magic_write_addrs got=%0h,%0h want=0,1", log_addr0[0], log_addr0[1]);
    end
    checks++; if (cpu_rst0 !== 1'b0 || done0 !== 1'b0 || dcyc != -1) begin
      errors++; $display("FAIL magic_cpu_held cpu_reset=%b done=%b want=0/0", cpu_rst0, done0);
    end
`else
    checks++; if (dcyc !== t0 + 131 || log_addr0.size() != 128) begin
      errors++; $display("FAIL nocheck_copy done_cycle=%0d writes=%0d want=131/128", dcyc - t0, log_addr0.size());
    end
    checks++; if (ecyc != -1 || err0 !== 1'b0) begin errors++; $display("FAIL nocheck_error err=%b want=0", err0); end
    checks++; if (log_data0.size() < 3 || log_data0[2] !== 8'h00) begin
      errors++; $display("FAIL nocheck_byte2 size=%0d want byte2=00", log_data0.size());
    end
`endif
    rom[2] = 8'h52;
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = image_byte(i);
    test_reset();
    test_copy_default();
    test_restart_in_copy();
    test_restart_done();
    test_reset_midcopy();
    test_magic();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rom_boot_copier.md
# rom_boot_copier

Boot-time sequencer that sits directly downstream of the 128×8 boot ROM. It streams every ROM byte into the data RAM through the RAM write port, optionally checks the 4-byte program magic "ASRM", and holds the CPU in reset until the copy completes. It is the only ROM consumer after reset; the CPU never reads the ROM directly.

## Interface
Parameters:
- ROM_ADDR_W, 7, ROM address width; copy length is 2^ROM_ADDR_W bytes.
- RAM_ADDR_W, 8, RAM address width; must be ≥ ROM_ADDR_W.
- RAM_BASE, 0, RAM byte address that receives ROM byte 0.

Ports:
- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-low reset.
- restart  in  1  one-cycle pulse; restarts the copy from DONE or ERROR.
- rom_addr  out  ROM_ADDR_W  ROM read address.
- rom_enable_out  out  1  ROM output enable; ROM data reads 0 when low.
- rom_data  in  8  ROM read data, valid one cycle after the address is presented.
- ram_addr  out  RAM_ADDR_W  RAM write address.
- ram_data  out  8  RAM write data.
- ram_write_en  out  1  RAM write strobe, one byte per high cycle.
- cpu_reset  out  1  active-low CPU reset; 0 holds the CPU.
- done  out  1  copy completed successfully.
- error  out  1  magic mismatch (only with check compiled in).

## Operation
- States: IDLE, COPY, DONE, ERROR.
- Reset (reset=0 at posedge): state IDLE. rom_addr=0, rom_enable_out=0, ram_addr=RAM_BASE, ram_data=0, ram_write_en=0, cpu_reset=0, done=0, error=0.
- IDLE → COPY on the first edge with reset=1. In COPY, rom_enable_out=1 and rom_addr increments by 1 each cycle from 0 to 2^ROM_ADDR_W−1, then holds.
- Pipeline: the byte for address A arrives on rom_data one cycle after rom_addr=A. On that cycle the block registers ram_addr=RAM_BASE+A, ram_data=rom_data, ram_write_en=1, so the write strobe is visible one cycle later.
- RAM address arithmetic is RAM_ADDR_W bits wide and wraps modulo 2^RAM_ADDR_W.
- The last byte (A=2^ROM_ADDR_W−1) is written, then the state becomes DONE.
- DONE: rom_enable_out=0, ram_write_en=0, done=1, and cpu_reset=1 from the same edge that sets done.
- ERROR: rom_enable_out=0, ram_write_en=0, error=1, cpu_reset=0 (CPU held indefinitely).
- restart pulse in DONE or ERROR: clear done and error, drive cpu_reset=0, reset the address counters, enter COPY on the next edge. restart is ignored in IDLE and COPY.
- reset=0 in any state, including mid-copy: all outputs return to their reset values at that edge. A write already registered is dropped, because ram_write_en is forced to 0.

## Timing
- First ROM address is presented 1 cycle after reset deasserts.
- First RAM write strobe appears 3 cycles after reset deasserts.
- With N=2^ROM_ADDR_W, there are N consecutive write cycles with no gaps.
- done and cpu_reset rise together one cycle after the last write strobe: N+3 cycles after reset deassertion, which is 131 cycles for the defaults.
- restart to first RAM write strobe: 3 cycles.

## Configuration
- BOOT_MAGIC_CHECK_EN defined:
  - Bytes 0..3 are compared against 0x41, 0x53, 0x52, 0x4D as they arrive.
  - On the first mismatching byte k, that byte is not written and the block enters ERROR on the same edge.
  - Bytes before k have already been written and remain.
- BOOT_MAGIC_CHECK_EN undefined:
  - No comparison is made.
  - All N bytes are copied unconditionally; ERROR is unreachable and error is tied to 0.

## Test plan
- Default ROM image, check enabled → 128 writes with RAM[0..3]=41 53 52 4D, RAM[0x5F]=0x08, RAM[0x60..0x7F]=0; done=1, cpu_reset=1 at cycle 131, error=0.
- ROM byte 2 = 0x00, check enabled → writes only to addresses 0 and 1, then error=1, cpu_reset stays 0, no further strobes. Same image with check disabled → 128 writes, done=1.
- RAM_BASE=0xF0, RAM_ADDR_W=8 → byte 0x10 is written at RAM address 0x00 (wrap); every ram_addr equals (0xF0+A) mod 256.
- reset pulled low at byte 50 mid-copy → ram_write_en=0 and all outputs at reset values on that edge; after release, the copy restarts from address 0 and completes at N+3 cycles.
- restart pulse in DONE → done=0 and cpu_reset=0 next cycle, first write strobe 3 cycles after restart, full recopy, done again. restart pulse during COPY → ignored, timing unchanged.
